sysarray_ctrl: RTL and testbench

Sequencer for the 3x3 half-precision systolic array. On `start` it reads matrix A (9 words) and matrix B (9 words) from the single-port block RAM. It then drives the skewed a/b wavefronts into the array's edge inputs, captures the nine C elements from the array's output edge, and signals `done`. It replaces free-running counter sequencing with a start/busy/done handshake usable by a host or VIO.

---
 rtl/sysarray_ctrl.sv | 149 ++++++++++++++
 tb/tb_sysarray_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_ctrl.sv
// Start/busy/done sequencer for the 3x3 systolic array: fetches A and B from block RAM,
// drives the skewed wavefronts into the array edge and captures the nine C elements.
module sysarray_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 5,
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 9,
    parameter int CAP_DLY = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            mem_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic [5*DW-1:0] a_feed,
    output logic [5*DW-1:0] b_feed,
    input  logic [5*DW-1:0] c_edge,
    output logic [9*DW-1:0] res
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         state, state_nx;
    logic [4:0]         cnt, cnt_nx;
    logic [8:0][DW-1:0] in_a, in_b;
    logic [4:0][DW-1:0] a_nx, b_nx;

    // cnt restarts at 0 on every state change; FETCH runs 19 cycles (18 reads + final data)
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 5'd1;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (start) state_nx = S_FETCH;
            end
            S_FETCH: if (cnt == 5'd18) begin
                state_nx = S_FEED;
                cnt_nx   = '0;
            end
            S_FEED: if (cnt == 5'd2) begin
                state_nx = (CAP_DLY == 3) ? S_CAPTURE : S_DRAIN;
                cnt_nx   = '0;
            end
            S_DRAIN: if (cnt == 5'(CAP_DLY - 4)) begin
                state_nx = S_CAPTURE;
                cnt_nx   = '0;
            end
            S_CAPTURE: if (cnt == 5'd2) begin
                state_nx = S_DONE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Feed lanes for the coming cycle; wavefront f enters lanes f..f+2
    always_comb begin
        a_nx = '0;
        b_nx = '0;
        if (state_nx == S_FEED) begin
            case (cnt_nx[1:0])
                2'd0: for (int i = 0; i < 3; i++) begin
                    a_nx[i] = in_a[i];
                    b_nx[i] = in_b[3*i];
                end
                2'd1: for (int i = 0; i < 3; i++) begin
                    a_nx[i+1] = in_a[3+i];
                    b_nx[i+1] = in_b[3*i+1];
                end
                2'd2: for (int i = 0; i < 3; i++) begin
                    a_nx[i+2] = in_a[6+i];
                    b_nx[i+2] = in_b[3*i+2];
                end
                default: ;
            endcase
        end
    end

    // Read data for the address issued at FETCH cycle n arrives in cycle n+1
    always_ff @(posedge clock) begin
        if (state == S_FETCH) begin
            for (int i = 0; i < 9; i++) begin
                if (cnt == 5'(i + 1))  in_a[i] <= mem_data;
                if (cnt == 5'(i + 10)) in_b[i] <= mem_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            a_feed   <= '0;
            b_feed   <= '0;
            res      <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy   <= (state_nx == S_FETCH) || (state_nx == S_FEED) ||
                      (state_nx == S_DRAIN) || (state_nx == S_CAPTURE);
            done   <= (state_nx == S_DONE);
            a_feed <= a_nx;
            b_feed <= b_nx;
            if (state_nx == S_FETCH && cnt_nx < 5'd18) begin
                mem_en   <= 1'b1;
                mem_addr <= (cnt_nx < 5'd9) ? AW'(A_BASE) + AW'(cnt_nx)
                                            : AW'(B_BASE) + AW'(cnt_nx - 5'd9);
            end else begin
                mem_en   <= 1'b0;
                mem_addr <= '0;
            end
            if (state == S_IDLE && start) res <= '0;
            // Output edge lanes: 0=c53 1=c54 2=c55 3=c35 4=c45
            if (state == S_CAPTURE) begin
                case (cnt[1:0])
                    2'd0: begin
                        res[2*DW +: DW] <= c_edge[3*DW +: DW];
                        res[1*DW +: DW] <= c_edge[4*DW +: DW];
                        res[0*DW +: DW] <= c_edge[2*DW +: DW];
                        res[3*DW +: DW] <= c_edge[1*DW +: DW];
                        res[6*DW +: DW] <= c_edge[0*DW +: DW];
                    end
                    2'd1: begin
                        res[5*DW +: DW] <= c_edge[4*DW +: DW];
                        res[4*DW +: DW] <= c_edge[2*DW +: DW];
                        res[7*DW +: DW] <= c_edge[1*DW +: DW];
                    end
                    2'd2: res[8*DW +: DW] <= c_edge[2*DW +: DW];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sysarray_ctrl.sv
// Bench for sysarray_ctrl: RAM model, behavioral 3x3 array model, done-time scoreboard.
module tb_sysarray_ctrl;
    typedef struct {
        logic [143:0] res;
        int           t_done;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         start0 = 1'b0, start1 = 1'b0;
    logic         busy0, done0, mem_en0, busy1, done1, mem_en1;
    logic [4:0]   mem_addr0, mem_addr1;
    logic [15:0]  mem_data0 = '0, mem_data1 = '0;
    logic [79:0]  a_feed0, b_feed0, a_feed1, b_feed1;
    logic [79:0]  c_edge0 = '0, c_edge1 = '0;
    logic [143:0] res0, res1;

    sysarray_ctrl #(.CAP_DLY(5)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .a_feed(a_feed0), .b_feed(b_feed0), .c_edge(c_edge0), .res(res0)
    );
    sysarray_ctrl #(.CAP_DLY(6)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .a_feed(a_feed1), .b_feed(b_feed1), .c_edge(c_edge1), .res(res1)
    );

    int checks = 0, failures = 0;
    int cyc = 0, t0 = 0, base0 = -1000, base1 = -1000;
    exp_t q0[$], q1[$];
    logic [15:0] ram [32];
    logic [15:0] ra [9], rb [9];

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(int'(h[9:0])) / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        real  m;
        int   e, f;
        logic s;
        if (v == 0.0) return 16'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 15;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = int'((m - 1.0) * 1024.0);
        return {s, 5'(e), 10'(f)};
    endfunction

    function automatic logic [143:0] mm(input logic [15:0] a [9], input logic [15:0] b [9]);
        logic [143:0] c;
        real acc;
        c = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                acc = 0.0;
                for (int j = 0; j < 3; j++) acc += h2r(a[r*3+j]) * h2r(b[j*3+k]);
                c[(r*3+k)*16 +: 16] = r2h(acc);
            end
        return c;
    endfunction

    function automatic logic [79:0] feed_exp(input int n, input bit is_b);
        logic [79:0] v;
        int f;
        v = '0;
        if (n >= 20 && n <= 22) begin
            f = n - 20;
            for (int i = 0; i < 3; i++)
                v[(f+i)*16 +: 16] = is_b ? rb[i*3+f] : ra[f*3+i];
        end
        return v;
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_en0) mem_data0 <= ram[mem_addr0];
        if (mem_en1) mem_data1 <= ram[mem_addr1];
    end

    // Array model for dut0: rebuild A/B from the wavefronts, present C on the output edge
    logic [15:0]  fa [3][5], fb [3][5], ma [9], mb [9];
    logic [143:0] cmp;
    always @(negedge clock) begin
        int t;
        t = cyc - base0;
        if (t >= 20 && t <= 22)
            for (int k = 0; k < 5; k++) begin
                fa[t-20][k] = a_feed0[k*16 +: 16];
                fb[t-20][k] = b_feed0[k*16 +: 16];
            end
        if (t == 22) begin
            for (int f = 0; f < 3; f++)
                for (int i = 0; i < 3; i++) begin
                    ma[f*3+i] = fa[f][f+i];
                    mb[i*3+f] = fb[f][f+i];
                end
            cmp = mm(ma, mb);
        end
        c_edge0 = 80'({$urandom(), $urandom(), $urandom()});
        if (t == 25) c_edge0 = {cmp[1*16 +: 16], cmp[2*16 +: 16], cmp[0*16 +: 16],
                                cmp[3*16 +: 16], cmp[6*16 +: 16]};
        if (t == 26) begin
            c_edge0[4*16 +: 16] = cmp[5*16 +: 16];
            c_edge0[2*16 +: 16] = cmp[4*16 +: 16];
            c_edge0[1*16 +: 16] = cmp[7*16 +: 16];
        end
        if (t == 27) c_edge0[2*16 +: 16] = cmp[8*16 +: 16];
        // dut1 sees a cycle/lane tag so capture timing is directly visible in res
        for (int k = 0; k < 5; k++) c_edge1[k*16 +: 16] = {8'(cyc - base1), 8'(k)};
    end

    always @(negedge clock) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) chk("done0_spurious", 144'(1), 144'(0));
            else begin
                e = q0.pop_front();
                chk("res0", res0, e.res);
                chk("done0_time", 144'(cyc), 144'(e.t_done));
            end
        end
        if (done1) begin
            if (q1.size() == 0) chk("done1_spurious", 144'(1), 144'(0));
            else begin
                e = q1.pop_front();
                chk("res1", res1, e.res);
                chk("done1_time", 144'(cyc), 144'(e.t_done));
            end
        end
    end

    task automatic wr_ram();
        for (int i = 0; i < 9; i++) begin
            ram[i]     = ra[i];
            ram[9 + i] = rb[i];
        end
    endtask

    task automatic rand_ab();
        logic [15:0] vals [3];
        vals = '{16'h3C00, 16'h4000, 16'h4200};
        for (int i = 0; i < 9; i++) begin
            ra[i] = vals[$urandom_range(0, 2)];
            rb[i] = vals[$urandom_range(0, 2)];
        end
        wr_ram();
    endtask

    // Raise start0 in the current negedge cycle (T0) and book the expected result
    task automatic go0(input logic [143:0] e);
        start0 = 1'b1;
        base0  = cyc;
        t0     = cyc;
        q0.push_back('{res: e, t_done: cyc + 28});
    endtask

    task automatic step_to(input int n);
        while (cyc < t0 + n) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        repeat (3) @(negedge clock);
        chk("rst_ctl0", 144'({busy0, done0, mem_en0, mem_addr0}), 144'(0));
        chk("rst_feed0", 144'({a_feed0, b_feed0}), 144'(0));
        chk("rst_res0", res0, 144'(0));
        chk("rst_all1", 144'({busy1, done1, mem_en1, mem_addr1, a_feed1, b_feed1} | res1), 144'(0));
        reset = 1'b0;
        @(negedge clock);

        // identity x B
        for (int i = 0; i < 9; i++) begin
            ra[i] = (i % 4 == 0) ? 16'h3C00 : 16'h0000;
        end
        rb = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
               16'h4600, 16'h4700, 16'h4800, 16'h4880};
        wr_ram();
        go0({rb[8], rb[7], rb[6], rb[5], rb[4], rb[3], rb[2], rb[1], rb[0]});
        chk("id_busy_T0", 144'(busy0), 144'(0));
        for (int n = 1; n <= 29; n++) begin
            step_to(n);
            if (n == 1) start0 = 1'b0;
            chk($sformatf("id_busy_T%0d", n), 144'(busy0), 144'(n <= 27));
        end

        // all 2.0, address sequence
        @(negedge clock);
        for (int i = 0; i < 9; i++) begin ra[i] = 16'h4000; rb[i] = 16'h4000; end
        wr_ram();
        go0({9{16'h4A00}});
        for (int n = 1; n <= 19; n++) begin
            step_to(n);
            if (n == 1) start0 = 1'b0;
            chk($sformatf("two_en_T%0d", n), 144'(mem_en0), 144'(n <= 18));
            if (n <= 18) chk($sformatf("two_addr_T%0d", n), 144'(mem_addr0), 144'(n - 1));
        end
        step_to(30);

        // feed skew
        for (int i = 0; i < 9; i++) begin ra[i] = 16'h0100 + 16'(i); rb[i] = 16'h0200 + 16'(i); end
        wr_ram();
        go0(mm(ra, rb));
        for (int n = 1; n <= 28; n++) begin
            step_to(n);
            if (n == 1) start0 = 1'b0;
            chk($sformatf("skew_a_T%0d", n), 144'(a_feed0), 144'(feed_exp(n, 1'b0)));
            chk($sformatf("skew_b_T%0d", n), 144'(b_feed0), 144'(feed_exp(n, 1'b1)));
        end
        step_to(30);

        // reset mid-run
        rand_ab();
        go0(mm(ra, rb));
        step_to(1);
        start0 = 1'b0;
        step_to(22);
        reset = 1'b1;
        step_to(23);
        reset = 1'b0;
        q0.delete();
        base0 = -1000;
        chk("mid_rst_ctl", 144'({busy0, done0, mem_en0, mem_addr0}), 144'(0));
        chk("mid_rst_data", 144'({a_feed0, b_feed0}) | res0, 144'(0));
        step_to(60);
        rand_ab();
        go0(mm(ra, rb));
        step_to(1);
        start0 = 1'b0;
        step_to(30);

        // ignored pulse, then start held high across DONE
        rand_ab();
        go0(mm(ra, rb));
        step_to(1);
        start0 = 1'b0;
        step_to(10);
        start0 = 1'b1;
        step_to(11);
        start0 = 1'b0;
        chk("ign_busy_T11", 144'(busy0), 144'(1));
        step_to(15);
        start0 = 1'b1;
        step_to(20);
        rand_ab();
        step_to(29);
        chk("b2b_busy_T29", 144'(busy0), 144'(0));
        base0 = cyc;
        q0.push_back('{res: mm(ra, rb), t_done: cyc + 28});
        step_to(30);
        start0 = 1'b0;
        chk("b2b_res_clr_T30", res0, 144'(0));
        chk("b2b_busy_T30", 144'(busy0), 144'(1));
        step_to(60);

        // CAP_DLY=6 on the second instance
        start1 = 1'b1;
        base1  = cyc;
        t0     = cyc;
        q1.push_back('{res: {16'h1C02, 16'h1B01, 16'h1A00, 16'h1B04, 16'h1B02,
                             16'h1A01, 16'h1A03, 16'h1A04, 16'h1A02},
                       t_done: cyc + 29});
        step_to(1);
        start1 = 1'b0;
        step_to(28);
        chk("cd6_busy_T28", 144'(busy1), 144'(1));
        step_to(29);
        chk("cd6_busy_T29", 144'(busy1), 144'(0));
        step_to(32);

        chk("q0_pending", 144'(q0.size()), 144'(0));
        chk("q1_pending", 144'(q1.size()), 144'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
